// File: rtl/mat_proc_mem_responder.sv
// Memory responder for the matrix processor: fixed-latency reads over a
// single-port SRAM, with a posted write buffer and a one-word read cache.
module mat_proc_mem_responder #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 12,
  parameter int WB_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     readAddr,
  output logic [WIDTH-1:0]     dataIn,
  input  logic [WIDTH-1:0]     writeAddr,
  input  logic [WIDTH-1:0]     writeData,
  input  logic                 writeEn,
  output logic                 sramEn,
  output logic                 sramWe,
  output logic [ADDR_BITS-1:0] sramAddr,
  output logic [WIDTH-1:0]     sramWData,
  input  logic [WIDTH-1:0]     sramRData,
  output logic                 wbEmpty,
  output logic                 wbOverflow
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(WB_DEPTH);

  logic [ADDR_BITS-1:0] r_idx;
  logic [ADDR_BITS-1:0] w_idx;
  logic                 unused_addr_bits;

  logic [ADDR_BITS-1:0] wb_idx  [WB_DEPTH];
  logic [WIDTH-1:0]     wb_data [WB_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_nxt;
  logic                 wb_empty_q;
  logic                 overflow_q;

  logic                 last_valid;
  logic [ADDR_BITS-1:0] last_addr;
  logic [WIDTH-1:0]     held_word;
  logic                 held_from_sram;
  logic [WIDTH-1:0]     held_eff;
  logic [WIDTH-1:0]     data_q;
  logic                 rd_sram_q;

  logic [PW-1:0]        slot;
  logic                 fwd_hit;
  logic [WIDTH-1:0]     fwd_data;
  logic                 held_hit;
  logic                 miss;
  logic                 drain;
  logic                 full;
  logic                 enq;
  logic                 deq;
  logic                 drop;
  logic                 held_upd;

  assign r_idx = readAddr[ADDR_BITS+1:2];
  assign w_idx = writeAddr[ADDR_BITS+1:2];
  assign unused_addr_bits = ^{readAddr[WIDTH-1:ADDR_BITS+2], readAddr[1:0],
                              writeAddr[WIDTH-1:ADDR_BITS+2], writeAddr[1:0]};

  // Walk entries oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      slot = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (wb_idx[slot] == r_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[slot];
      end
    end
  end

  // A miss last cycle leaves the held word arriving on sramRData now.
  assign held_eff  = held_from_sram ? sramRData : held_word;
  assign held_hit  = last_valid && (last_addr == r_idx);
  assign miss      = !fwd_hit && !held_hit;
  assign drain     = !miss && (count != '0);
  assign deq       = drain;
  assign full      = (count == FULL);
  assign enq       = writeEn && (!full || deq);
  assign drop      = writeEn && full && !deq;
  assign held_upd  = enq && (w_idx == r_idx);
  assign count_nxt = count + CW'(enq) - CW'(deq);

  assign sramEn     = rst_n && (miss || drain);
  assign sramWe     = rst_n && drain;
  assign sramAddr   = miss ? r_idx : wb_idx[rd_ptr];
  assign sramWData  = wb_data[rd_ptr];
  assign dataIn     = rd_sram_q ? sramRData : data_q;
  assign wbEmpty    = wb_empty_q;
  assign wbOverflow = overflow_q;

  always_ff @(posedge clk) begin
    if (enq) begin
      wb_idx[wr_ptr]  <= w_idx;
      wb_data[wr_ptr] <= writeData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      wb_empty_q     <= 1'b1;
      overflow_q     <= 1'b0;
      last_valid     <= 1'b0;
      last_addr      <= '0;
      held_word      <= '0;
      held_from_sram <= 1'b0;
      data_q         <= '0;
      rd_sram_q      <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count      <= count_nxt;
      wb_empty_q <= (count_nxt == '0);
      if (drop) overflow_q <= 1'b1;
      last_valid <= 1'b1;
      last_addr  <= r_idx;
      rd_sram_q  <= miss;
      data_q     <= fwd_hit ? fwd_data : held_eff;
      // A write to the newly held address supersedes both forward and SRAM data.
      held_word      <= held_upd ? writeData : (fwd_hit ? fwd_data : held_eff);
      held_from_sram <= miss && !held_upd;
    end
  end

endmodule

// File: tb/tb_mat_proc_mem_responder.sv
// Bench for mat_proc_mem_responder: directed table, random traffic against a
// queue/array memory model, and overflow / reset-mid-drain sequences.
module tb_mat_proc_mem_responder;

  localparam int WIDTH = 32;
  localparam int AB    = 12;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [WIDTH-1:0]  readAddr, writeAddr, writeData, dataIn, sramWData;
  logic              writeEn, sramEn, sramWe, wbEmpty, wbOverflow;
  logic [AB-1:0]     sramAddr;
  logic [WIDTH-1:0]  sram_rdata;

  always #5 clk = ~clk;

  mat_proc_mem_responder #(.WIDTH(WIDTH), .ADDR_BITS(AB), .WB_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .readAddr(readAddr), .dataIn(dataIn),
    .writeAddr(writeAddr), .writeData(writeData), .writeEn(writeEn),
    .sramEn(sramEn), .sramWe(sramWe), .sramAddr(sramAddr), .sramWData(sramWData),
    .sramRData(sram_rdata), .wbEmpty(wbEmpty), .wbOverflow(wbOverflow)
  );

  // SRAM model: one-cycle read latency, read data held until the next read.
  logic [31:0] mem [0:4095];
  int          sram_wr_cnt;
  logic        load_req;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 4096; i++)
        mem[i] <= (i == 5) ? 32'hA5A5_A5A5 : (32'hC000_0000 | 32'(i));
      sram_wr_cnt <= 0;
    end else if (sramEn) begin
      if (sramWe) begin
        mem[sramAddr] <= sramWData;
        sram_wr_cnt   <= sram_wr_cnt + 1;
      end else begin
        sram_rdata <= mem[sramAddr];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural memory plus a queue of posted writes.
  logic [31:0] arch [0:4095];
  logic [11:0] q_idx [$];
  logic [31:0] q_dat [$];
  logic        m_lv;
  logic [11:0] m_last;
  logic [31:0] m_exp;
  logic        m_ovf;

  task automatic model_reset();
    q_idx.delete();
    q_dat.delete();
    m_lv  = 1'b0;
    m_last = '0;
    m_exp = '0;
    m_ovf = 1'b0;
    for (int i = 0; i < 4096; i++) arch[i] = mem[i];
  endtask

  task automatic model_step(input logic [31:0] ra, input logic we,
                            input logic [31:0] wa, input logic [31:0] wd);
    logic [11:0] idx, widx;
    logic fwd, hit, rd, dr;
    idx  = ra[13:2];
    widx = wa[13:2];
    fwd  = 1'b0;
    foreach (q_idx[i]) if (q_idx[i] == idx) fwd = 1'b1;
    hit = !fwd && m_lv && (m_last == idx);
    rd  = !fwd && !hit;
    dr  = !rd && (q_idx.size() != 0);
    chk("sram_en", sramEn, rd || dr);
    chk("sram_we", sramWe, dr);
    if (rd) chk("sram_rd_addr", sramAddr, idx);
    if (dr) begin
      chk("drain_addr", sramAddr, q_idx[0]);
      chk("drain_data", sramWData, q_dat[0]);
    end
    chk("data_in", dataIn, m_exp);
    chk("wb_empty", wbEmpty, q_idx.size() == 0);
    chk("wb_overflow", wbOverflow, m_ovf);
    m_exp = arch[idx];
    if (dr) begin
      void'(q_idx.pop_front());
      void'(q_dat.pop_front());
    end
    if (we) begin
      if (q_idx.size() < DEPTH) begin
        q_idx.push_back(widx);
        q_dat.push_back(wd);
        arch[widx] = wd;
      end else begin
        m_ovf = 1'b1;
      end
    end
    m_lv   = 1'b1;
    m_last = idx;
  endtask

  task automatic drive(input logic [31:0] ra, input logic we,
                       input logic [31:0] wa, input logic [31:0] wd);
    readAddr  = ra;
    writeEn   = we;
    writeAddr = wa;
    writeData = wd;
  endtask

  task automatic cyc(input logic [31:0] ra, input logic we,
                     input logic [31:0] wa, input logic [31:0] wd);
    drive(ra, we, wa, wd);
    @(negedge clk);
    model_step(ra, we, wa, wd);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive('0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [31:0] ra;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        en;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdat;
    logic [31:0] data;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [31:0] r, ra, wa;
    logic [11:0] ri, wi;
    int base;

    tbl[0]  = '{32'h14, 1'b1, 32'h40, 32'h11,       1'b1, 1'b0, 12'd5,  32'h0,        32'h0};
    tbl[1]  = '{32'h14, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 12'd16, 32'h11,       32'hA5A5_A5A5};
    tbl[2]  = '{32'h14, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 12'd0,  32'h0,        32'hA5A5_A5A5};
    tbl[3]  = '{32'h14, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 12'd0,  32'h0,        32'hA5A5_A5A5};
    tbl[4]  = '{32'h14, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 12'd0,  32'h0,        32'hA5A5_A5A5};
    tbl[5]  = '{32'h14, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 12'd0,  32'h0,        32'hA5A5_A5A5};
    tbl[6]  = '{32'h14, 1'b1, 32'h20, 32'h1,        1'b0, 1'b0, 12'd0,  32'h0,        32'hA5A5_A5A5};
    tbl[7]  = '{32'h14, 1'b1, 32'h20, 32'h2,        1'b1, 1'b1, 12'd8,  32'h1,        32'hA5A5_A5A5};
    tbl[8]  = '{32'h20, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 12'd8,  32'h2,        32'hA5A5_A5A5};
    tbl[9]  = '{32'h20, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 12'd0,  32'h0,        32'h2};
    tbl[10] = '{32'h17, 1'b1, 32'h14, 32'hDEAD_BEEF, 1'b1, 1'b0, 12'd5,  32'h0,        32'h2};
    tbl[11] = '{32'h17, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 12'd5,  32'hDEAD_BEEF, 32'hA5A5_A5A5};
    tbl[12] = '{32'h14, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 12'd0,  32'h0,        32'hDEAD_BEEF};
    tbl[13] = '{32'h16, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 12'd0,  32'h0,        32'hDEAD_BEEF};

    load_req = 1'b1;
    rst_n    = 1'b0;
    drive('0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    load_req = 1'b0;
    rst_n    = 1'b1;
    model_reset();
    chk("reset_wb_empty", wbEmpty, 1'b1);
    chk("reset_overflow", wbOverflow, 1'b0);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].ra, tbl[i].we, tbl[i].wa, tbl[i].wd);
      @(negedge clk);
      chk($sformatf("tbl%0d_sram_en", i), sramEn, tbl[i].en);
      chk($sformatf("tbl%0d_sram_we", i), sramWe, tbl[i].wr);
      if (tbl[i].en) chk($sformatf("tbl%0d_sram_addr", i), sramAddr, tbl[i].addr);
      if (tbl[i].wr) chk($sformatf("tbl%0d_sram_wdata", i), sramWData, tbl[i].wdat);
      chk($sformatf("tbl%0d_data_in", i), dataIn, tbl[i].data);
      model_step(tbl[i].ra, tbl[i].we, tbl[i].wa, tbl[i].wd);
      @(posedge clk);
      #1;
    end

    // Random traffic over a small word set; upper and byte bits are noise.
    for (int n = 0; n < 2000; n++) begin
      r  = $urandom();
      ri = 12'h300 + 12'($urandom_range(0, 11));
      ra = {r[31:14], ri, r[1:0]};
      r  = $urandom();
      wi = 12'h300 + 12'($urandom_range(0, 11));
      wa = {r[31:14], wi, r[1:0]};
      cyc(ra, ($urandom_range(0, 99) < 45), wa, $urandom());
    end

    // Continuous misses starve the drain: fifth write must be dropped.
    do_reset();
    for (int k = 0; k < 5; k++)
      cyc(32'h1000 + 32'(4 * k), 1'b1, 32'h2000 + 32'(4 * k), 32'h5000 + 32'(k));
    chk("ovf_flag_set", wbOverflow, 1'b1);
    chk("ovf_not_empty", wbEmpty, 1'b0);
    repeat (6) cyc(32'h1010, 1'b0, '0, '0);
    for (int k = 0; k < 4; k++)
      chk($sformatf("ovf_mem%0d", k), mem[12'h800 + 12'(k)], 32'h5000 + 32'(k));
    chk("ovf_dropped_mem", mem[12'h804], 32'hC000_0804);
    chk("ovf_drained_empty", wbEmpty, 1'b1);
    chk("ovf_sticky", wbOverflow, 1'b1);

    // Reset while the buffer is draining.
    cyc(32'h3000, 1'b1, 32'h3800, 32'h77);
    cyc(32'h3004, 1'b1, 32'h3804, 32'h78);
    cyc(32'h3008, 1'b1, 32'h3808, 32'h79);
    base = sram_wr_cnt;
    cyc(32'h3008, 1'b0, '0, '0);
    drive(32'h3008, 1'b0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_sram_en", sramEn, 1'b0);
    chk("rst_sram_we", sramWe, 1'b0);
    chk("rst_wb_empty", wbEmpty, 1'b1);
    chk("rst_data_in", dataIn, 32'h0);
    chk("rst_overflow", wbOverflow, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_hold_we%0d", k), sramWe, 1'b0);
    end
    rst_n = 1'b1;
    chk("rst_wr_count", 32'(sram_wr_cnt - base), 32'd1);
    chk("rst_first_drained", mem[12'hE00], 32'h77);
    chk("rst_discard_1", mem[12'hE01], 32'hC000_0E01);
    chk("rst_discard_2", mem[12'hE02], 32'hC000_0E02);
    model_reset();
    drive(32'h3008, 1'b0, '0, '0);
    @(negedge clk);
    chk("post_rst_miss_en", sramEn, 1'b1);
    chk("post_rst_miss_we", sramWe, 1'b0);
    model_step(32'h3008, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    repeat (4) cyc(32'h3008, 1'b0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
